uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares the single SoC UART transmit line between two byte sources: port 0
//   (CPU peripheral write) and port 1 (debug/trace monitor).
//   Round-robin arbitration with an optional message lock, so multi-byte
//   messages do not interleave.
//   Serialises the granted byte as 8N1, LSB first, on uart_tx. The bench's
//   115200-baud receiver decodes this line.
// PARAMETERS
//   CLOCK_FREQ  10000000  system clock in Hz
//   BAUD_RATE   115200    line rate
//   DIV         (CLOCK_FREQ+BAUD_RATE/2)/BAUD_RATE  clocks per bit (87 at defaults), derived
// PORTS
//   CLK       in   1  system clock, rising edge
//   RSTb      in   1  asynchronous active-low reset
//   p0_data   in   8  port 0 byte
//   p0_valid  in   1  port 0 byte pending
//   p0_lock   in   1  port 0 holds grant after this byte
//   p0_ready  out  1  port 0 byte accepted this cycle (valid & ready)
//   p1_data   in   8  port 1 byte
//   p1_valid  in   1  port 1 byte pending
//   p1_lock   in   1  port 1 holds grant after this byte
//   p1_ready  out  1  port 1 byte accepted this cycle
//   grant     out  1  port whose byte is in flight or last sent
//   busy      out  1  serialiser not IDLE
//   uart_tx   out  1  serial line, idle high
// BEHAVIOUR
//   Reset (async, RSTb=0): state=IDLE, uart_tx=1, busy=0, grant=0.
//     Also p0_ready=p1_ready=0, rr pointer=0, owner=none, bit/baud counters=0.
//     A reset mid-frame returns uart_tx to 1 immediately; the partial frame is dropped.
//   FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE, arbitration (combinational, evaluated every IDLE cycle):
//     - If owner set: only the owner port is eligible.
//     - Else: if both ports are valid, the port != rr pointer wins.
//     - Else: the single valid port wins.
//     - Winner's ready=1 in that cycle; the other ready=0. Ready is never 1
//       outside IDLE.
//   Accept (valid & ready):
//     - Latch data into the shift register; grant=winner; rr pointer=winner.
//     - owner = lock ? winner : none.
//     - Next cycle: state=START, busy=1.
//   START: uart_tx=0 for DIV cycles.
//   DATA: 8 bits, LSB first, each held DIV cycles; bit counter 0..7.
//   STOP: uart_tx=1 for DIV cycles, then IDLE.
//   Timing:
//     - Byte period = 10*DIV + 1 cycles (one IDLE arbitration cycle).
//     - Back-to-back bytes: 871 cycles at defaults.
//   Baud counter: counts 0..DIV-1 and wraps, reloaded to 0 on each state
//     entry. No fractional accumulation.
//   Lock:
//     - The owner keeps exclusive access until it sends a byte with lock=0.
//     - An owner dropping valid stalls the other port indefinitely (by design).
//   Inputs are sampled only at accept; data/lock changes mid-frame have no effect.
//   Simultaneous valid from both ports with owner=none and rr=0: port 1 wins.
// TESTING
//   1 Reset: RSTb=0 at t=0, release at 150 ns.
//     -> uart_tx=1, busy=0, both ready=0 until a valid is seen.
//   2 p0 sends 0x55 alone.
//     -> p0_ready pulses for 1 cycle; uart_tx low for 87 cycles.
//     -> then 1,0,1,0,1,0,1,0 at 87 cycles each, then stop high.
//     -> busy=1 for 870 cycles; the bench receiver reads 'U'.
//   3 p0 and p1 both hold valid (0x41, 0x42) from reset.
//     -> order p1,p0,p1,p0...; line decodes "BABA".
//     -> consecutive starts 871 cycles apart.
//   4 p0 sends "OK\n" with lock=1,1,0 while p1 holds valid 0x23.
//     -> line decodes "OK\n#"; p1_ready stays 0 until the '\n' is accepted.
//   5 Assert RSTb=0 during DATA bit 3 of 0xA5.
//     -> uart_tx=1 in the same cycle.
//     -> after release, the next byte frames correctly from IDLE.
//   6 Change p0_data from 0x00 to 0xFF one cycle after accept.
//     -> the frame still carries 0x00; p0_ready stays 0 until IDLE.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - two-port round-robin byte arbiter with message lock, 8N1 UART serialiser
`timescale 1ns/1ps
module uart_tx_scheduler #(
  parameter int CLOCK_FREQ = 10000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       CLK,
  input  logic       RSTb,
  input  logic [7:0] p0_data,
  input  logic       p0_valid,
  input  logic       p0_lock,
  output logic       p0_ready,
  input  logic [7:0] p1_data,
  input  logic       p1_valid,
  input  logic       p1_lock,
  output logic       p1_ready,
  output logic       grant,
  output logic       busy,
  output logic       uart_tx
);

  localparam int DIV = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          grant_q, grant_d;
  logic          rr_q, rr_d;
  logic          own_valid_q, own_valid_d;
  logic          own_id_q, own_id_d;

  logic win;
  logic win_valid;
  logic baud_last;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      own_valid_q <= 1'b0;
      own_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      own_valid_q <= own_valid_d;
      own_id_q    <= own_id_d;
    end
  end

  // A locked owner is the only candidate; otherwise a tie goes to the port not served last.
  always_comb begin
    win       = 1'b0;
    win_valid = 1'b0;
    if (state_q == S_IDLE) begin
      if (own_valid_q) begin
        win       = own_id_q;
        win_valid = own_id_q ? p1_valid : p0_valid;
      end else if (p0_valid && p1_valid) begin
        win       = ~rr_q;
        win_valid = 1'b1;
      end else if (p1_valid) begin
        win       = 1'b1;
        win_valid = 1'b1;
      end else if (p0_valid) begin
        win       = 1'b0;
        win_valid = 1'b1;
      end
    end
  end

  assign p0_ready  = win_valid & ~win;
  assign p1_ready  = win_valid & win;
  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    own_valid_d = own_valid_q;
    own_id_d    = own_id_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          shift_d     = win ? p1_data : p0_data;
          grant_d     = win;
          rr_d        = win;
          own_valid_d = win ? p1_lock : p0_lock;
          own_id_d    = win;
          baud_d      = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Decoded from state so an asynchronous reset forces the line high at once.
  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign grant = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench with a 115200-baud line receiver
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam real BIT_NS = 1.0e9 / 115200.0;

  logic       CLK  = 1'b0;
  logic       RSTb = 1'b1;
  logic [7:0] p0_data = 8'h00;
  logic       p0_valid = 1'b0;
  logic       p0_lock = 1'b0;
  logic       p0_ready;
  logic [7:0] p1_data = 8'h00;
  logic       p1_valid = 1'b0;
  logic       p1_lock = 1'b0;
  logic       p1_ready;
  logic       grant;
  logic       busy;
  logic       uart_tx;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rx_q[$];
  logic [7:0] msg[3] = '{8'h4F, 8'h4B, 8'h0A};
  logic       lk[3]  = '{1'b1, 1'b1, 1'b0};

  uart_tx_scheduler dut (
    .CLK(CLK), .RSTb(RSTb),
    .p0_data(p0_data), .p0_valid(p0_valid), .p0_lock(p0_lock), .p0_ready(p0_ready),
    .p1_data(p1_data), .p1_valid(p1_valid), .p1_lock(p1_lock), .p1_ready(p1_ready),
    .grant(grant), .busy(busy), .uart_tx(uart_tx)
  );

  always #50 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      if (busy === 1'b0) break;
    end
    chk(tag, busy, 0);
  endtask

  initial begin : rx
    logic [7:0] b;
    b = 8'h00;
    @(posedge RSTb);
    forever begin
      @(negedge uart_tx);
      #(BIT_NS / 2.0);
      if (uart_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          #(BIT_NS);
          b[i] = uart_tx;
        end
        #(BIT_NS);
        if (uart_tx === 1'b1) rx_q.push_back(b);
      end
    end
  end

  initial begin : main
    int         t_acc[$];
    int         p_acc[$];
    int         bad;
    int         lo;
    int         nbusy;
    int         viol;
    int         both;
    int         idx;
    int         t_nl;
    int         t_p1;
    logic       adv;
    logic       e;
    logic [7:0] eb;
    logic [7:0] exp3[4];

    // 1: reset
    RSTb = 1'b0;
    #150;
    RSTb = 1'b1;
    @(negedge CLK);
    chk("t1_uart_tx", uart_tx, 1);
    chk("t1_busy", busy, 0);
    chk("t1_grant", grant, 0);
    chk("t1_p0_ready", p0_ready, 0);
    chk("t1_p1_ready", p1_ready, 0);

    // 2: lone 0x55 from p0, waveform checked cycle by cycle
    rx_q.delete();
    eb = 8'h55;
    p0_data = 8'h55;
    p0_valid = 1'b1;
    #1;
    chk("t2_p0_ready", p0_ready, 1);
    chk("t2_p1_ready", p1_ready, 0);
    bad = 0; lo = 0; nbusy = 0;
    for (int i = 1; i <= 871; i++) begin
      @(negedge CLK);
      if (i == 1) begin
        chk("t2_ready_pulse", p0_ready, 0);
        p0_valid = 1'b0;
      end
      if (i <= 87) e = 1'b0;
      else if (i <= 783) e = eb[(i - 88) / 87];
      else e = 1'b1;
      if (i <= 88 && uart_tx === 1'b0) lo++;
      if (i <= 870) begin
        if (uart_tx !== e) bad++;
        if (busy === 1'b1) nbusy++;
      end
    end
    chk("t2_start_len", lo, 87);
    chk("t2_wave_errs", bad, 0);
    chk("t2_busy_cycles", nbusy, 870);
    chk("t2_busy_end", busy, 0);
    chk("t2_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t2_rx_byte", rx_q[0], 8'h55);

    // 3: both ports valid from reset, alternating p1 first
    RSTb = 1'b0;
    p0_data = 8'h41; p1_data = 8'h42;
    p0_valid = 1'b1; p1_valid = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RSTb = 1'b1;
    rx_q.delete();
    both = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge CLK);
      #1;
      if (p0_ready && p1_ready) both++;
      if (p0_ready || p1_ready) begin
        t_acc.push_back(c);
        p_acc.push_back(p1_ready ? 1 : 0);
      end
      if (t_acc.size() == 4) break;
    end
    @(negedge CLK);
    p0_valid = 1'b0; p1_valid = 1'b0;
    chk("t3_accepts", t_acc.size(), 4);
    chk("t3_both_ready", both, 0);
    for (int k = 0; k < t_acc.size(); k++) begin
      chk($sformatf("t3_port_%0d", k), p_acc[k], (k % 2 == 0) ? 1 : 0);
      if (k > 0) chk($sformatf("t3_gap_%0d", k), t_acc[k] - t_acc[k-1], 871);
    end
    wait_idle("t3_idle");
    exp3 = '{8'h42, 8'h41, 8'h42, 8'h41};
    chk("t3_rx_count", rx_q.size(), 4);
    for (int k = 0; k < rx_q.size() && k < 4; k++)
      chk($sformatf("t3_rx_%0d", k), rx_q[k], exp3[k]);

    // 4: locked "OK\n" from p0 while p1 waits with '#'
    rx_q.delete();
    idx = 0; adv = 1'b0; viol = 0; t_nl = -1; t_p1 = -1;
    p0_data = msg[0]; p0_lock = lk[0]; p0_valid = 1'b1;
    p1_data = 8'h23; p1_lock = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge CLK);
      if (adv) begin
        adv = 1'b0;
        idx++;
        if (idx < 3) begin
          p0_data = msg[idx];
          p0_lock = lk[idx];
        end else begin
          p0_valid = 1'b0;
        end
        if (idx == 1) p1_valid = 1'b1;
      end
      #1;
      if (p1_ready) begin
        if (t_nl < 0) viol++;
        t_p1 = c;
        break;
      end
      if (p0_ready) begin
        adv = 1'b1;
        if (idx == 2) t_nl = c;
      end
    end
    @(negedge CLK);
    p1_valid = 1'b0;
    chk("t4_p1_early", viol, 0);
    chk("t4_p0_bytes", idx, 3);
    chk("t4_p1_gap", t_p1 - t_nl, 871);
    wait_idle("t4_idle");
    chk("t4_grant", grant, 1);
    chk("t4_rx_count", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      chk("t4_rx_0", rx_q[0], 8'h4F);
      chk("t4_rx_1", rx_q[1], 8'h4B);
      chk("t4_rx_2", rx_q[2], 8'h0A);
      chk("t4_rx_3", rx_q[3], 8'h23);
    end

    // 5: reset during data bit 3 of 0xA5
    p0_data = 8'hA5; p0_lock = 1'b0; p0_valid = 1'b1;
    #1;
    chk("t5_p0_ready", p0_ready, 1);
    for (int i = 1; i <= 380; i++) begin
      @(negedge CLK);
      if (i == 1) p0_valid = 1'b0;
    end
    chk("t5_bit3_low", uart_tx, 0);
    chk("t5_busy_pre", busy, 1);
    RSTb = 1'b0;
    #1;
    chk("t5_tx_reset", uart_tx, 1);
    chk("t5_busy_reset", busy, 0);
    @(negedge CLK);
    @(negedge CLK);
    RSTb = 1'b1;
    for (int i = 0; i < 1000; i++) @(negedge CLK);
    rx_q.delete();
    p1_data = 8'h3C; p1_valid = 1'b1;
    #1;
    chk("t5_p1_ready", p1_ready, 1);
    @(negedge CLK);
    p1_valid = 1'b0;
    wait_idle("t5_idle");
    chk("t5_grant", grant, 1);
    chk("t5_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t5_rx_byte", rx_q[0], 8'h3C);

    // 6: data changed after accept must not reach the line
    rx_q.delete();
    p0_data = 8'h00; p0_valid = 1'b1;
    #1;
    chk("t6_p0_ready", p0_ready, 1);
    viol = 0;
    for (int i = 1; i <= 871; i++) begin
      @(negedge CLK);
      if (i == 1) p0_data = 8'hFF;
      #1;
      if (i <= 870 && p0_ready !== 1'b0) viol++;
      if (i == 871) begin
        chk("t6_ready_at_idle", p0_ready, 1);
        p0_valid = 1'b0;
      end
    end
    chk("t6_ready_busy", viol, 0);
    chk("t6_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t6_rx_byte", rx_q[0], 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
